// File: rtl/out_sel_scan.sv
// ---------------------------------------------------------------------------
// out_sel_scan
// Registered N-channel output selector for the calculator datapath.
// Manual mode passes the channel chosen by sel; scan mode rotates through all
// channels, holding each one for DIV cycles, to drive multiplexed display
// digit enables.
//
// Ports
//   clk     rising-edge clock
//   rst_n   synchronous active-low reset
//   mode    0 = manual, 1 = scan
//   sel     manual channel index (ignored in scan mode)
//   freeze  1 = every register holds
//   in_bus  channel k at bits [k*WIDTH +: WIDTH]
//   out     selected channel data (registered)
//   out_ch  index of the channel on out (registered)
//   ch_en   one-hot enable of the channel on out, zero when blanked
//   tick    one-cycle pulse when the scan advances to a new channel
// ---------------------------------------------------------------------------
module out_sel_scan #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int DIV   = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     mode,
    input  logic [$clog2(NCH)-1:0]   sel,
    input  logic                     freeze,
    input  logic [NCH*WIDTH-1:0]     in_bus,
    output logic [WIDTH-1:0]         out,
    output logic [$clog2(NCH)-1:0]   out_ch,
    output logic [NCH-1:0]           ch_en,
    output logic                     tick
);

    localparam int SELW = $clog2(NCH);
    localparam int CNTW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DIV - 1);
    localparam logic [SELW-1:0] CH_LAST  = SELW'(NCH - 1);

    logic [WIDTH-1:0] out_q,    out_d;
    logic [SELW-1:0]  out_ch_q, out_ch_d;
    logic [NCH-1:0]   ch_en_q,  ch_en_d;
    logic             tick_q,   tick_d;
    logic [CNTW-1:0]  cnt_q,    cnt_d;
    logic [SELW-1:0]  ch_q,     ch_d;
    logic             mode_q,   mode_d;

    // Channel that all three data outputs are loaded from this cycle.
    logic [SELW-1:0]  ch_next_s;

    // Dwell counter, scan channel and channel-to-present decision.
    always_comb begin
        cnt_d     = {CNTW{1'b0}};
        ch_d      = {SELW{1'b0}};
        tick_d    = 1'b0;
        ch_next_s = {SELW{1'b0}};
        mode_d    = mode;
        if (!mode) begin
            // Manual: present sel; scan state clears so a later entry restarts.
            ch_next_s = sel;
        end else if (!mode_q) begin
            // Scan entry: channel 0 with the entry cycle as the first of its dwell.
            ch_next_s = {SELW{1'b0}};
        end else if (cnt_q == CNT_LAST) begin
            // End of dwell: advance, wrapping explicitly for non-power-of-2 NCH.
            ch_next_s = (ch_q == CH_LAST) ? {SELW{1'b0}} : ch_q + SELW'(1);
            ch_d      = ch_next_s;
            tick_d    = 1'b1;
        end else begin
            cnt_d     = cnt_q + CNTW'(1);
            ch_next_s = ch_q;
            ch_d      = ch_q;
        end
    end

    // AND-OR data mux and one-hot enable; an out-of-range index matches no
    // channel and so yields the blanked all-zero state.
    always_comb begin
        out_d    = {WIDTH{1'b0}};
        ch_en_d  = {NCH{1'b0}};
        out_ch_d = ch_next_s;
        for (int k = 0; k < NCH; k++) begin
            ch_en_d[k] = (ch_next_s == SELW'(k));
            out_d      = out_d | ({WIDTH{ch_en_d[k]}} & in_bus[k*WIDTH +: WIDTH]);
        end
    end

    // State and output registers: reset dominates, freeze holds everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q    <= {WIDTH{1'b0}};
            out_ch_q <= {SELW{1'b0}};
            ch_en_q  <= {NCH{1'b0}};
            tick_q   <= 1'b0;
            cnt_q    <= {CNTW{1'b0}};
            ch_q     <= {SELW{1'b0}};
            mode_q   <= 1'b0;
        end else if (!freeze) begin
            out_q    <= out_d;
            out_ch_q <= out_ch_d;
            ch_en_q  <= ch_en_d;
            tick_q   <= tick_d;
            cnt_q    <= cnt_d;
            ch_q     <= ch_d;
            mode_q   <= mode_d;
        end
    end

    assign out    = out_q;
    assign out_ch = out_ch_q;
    assign ch_en  = ch_en_q;
    assign tick   = tick_q;

endmodule

// File: tb/tb_out_sel_scan.sv
// ---------------------------------------------------------------------------
// tb_out_sel_scan
// Three instances share the stimulus: NCH=4/DIV=4, NCH=3/DIV=4 and
// NCH=2/DIV=1. A reference model tracks, per instance, the number of cycles
// spent in scan since entry; the channel and tick follow from that by
// division and remainder.
// ---------------------------------------------------------------------------
module tb_out_sel_scan;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mode;
    logic        freeze;
    logic [1:0]  sel;
    logic [31:0] bus;

    logic [7:0] o0, o1, o2;
    logic [1:0] oc0, oc1;
    logic [0:0] oc2;
    logic [3:0] en0;
    logic [2:0] en1;
    logic [1:0] en2;
    logic       t0, t1, t2;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state
    int   nch_a[3] = '{4, 3, 2};
    int   div_a[3] = '{4, 4, 1};
    bit   m_prev[3];
    int   m_phase[3];
    int   e_ch[3];
    int   e_out[3];
    int   e_en[3];
    bit   e_tick[3];

    int scan_exp[17] = '{0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0};

    always #5 clk = ~clk;

    out_sel_scan #(.WIDTH(8), .NCH(4), .DIV(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .freeze(freeze),
        .in_bus(bus), .out(o0), .out_ch(oc0), .ch_en(en0), .tick(t0));

    out_sel_scan #(.WIDTH(8), .NCH(3), .DIV(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .freeze(freeze),
        .in_bus(bus[23:0]), .out(o1), .out_ch(oc1), .ch_en(en1), .tick(t1));

    out_sel_scan #(.WIDTH(8), .NCH(2), .DIV(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel[0]), .freeze(freeze),
        .in_bus(bus[15:0]), .out(o2), .out_ch(oc2), .ch_en(en2), .tick(t2));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_step();
        for (int d = 0; d < 3; d++) begin
            int s;
            s = (d == 2) ? int'(sel[0]) : int'(sel);
            if (!rst_n) begin
                m_prev[d] = 1'b0; m_phase[d] = 0;
                e_ch[d] = 0; e_out[d] = 0; e_en[d] = 0; e_tick[d] = 1'b0;
            end else if (!freeze) begin
                if (mode) begin
                    m_phase[d] = m_prev[d] ? m_phase[d] + 1 : 0;
                    e_ch[d]    = (m_phase[d] / div_a[d]) % nch_a[d];
                    e_tick[d]  = (m_phase[d] != 0) && (m_phase[d] % div_a[d] == 0);
                end else begin
                    e_ch[d]   = s;
                    e_tick[d] = 1'b0;
                end
                m_prev[d] = mode;
                if (e_ch[d] < nch_a[d]) begin
                    e_out[d] = int'(bus[e_ch[d]*8 +: 8]);
                    e_en[d]  = 1 << e_ch[d];
                end else begin
                    e_out[d] = 0;
                    e_en[d]  = 0;
                end
            end
        end
    endtask

    task automatic compare_all();
        check("d0_out", 32'(o0),  32'(e_out[0]));
        check("d0_ch",  32'(oc0), 32'(e_ch[0]));
        check("d0_en",  32'(en0), 32'(e_en[0]));
        check("d0_tick",32'(t0),  32'(e_tick[0]));
        check("d1_out", 32'(o1),  32'(e_out[1]));
        check("d1_ch",  32'(oc1), 32'(e_ch[1]));
        check("d1_en",  32'(en1), 32'(e_en[1]));
        check("d1_tick",32'(t1),  32'(e_tick[1]));
        check("d2_out", 32'(o2),  32'(e_out[2]));
        check("d2_ch",  32'(oc2), 32'(e_ch[2]));
        check("d2_en",  32'(en2), 32'(e_en[2]));
        check("d2_tick",32'(t2),  32'(e_tick[2]));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    initial begin
        // reset overrides freeze and scan request
        rst_n = 1'b0; freeze = 1'b1; mode = 1'b1; sel = 2'd0; bus = 32'hA5A5_A5A5;
        cycle();
        check("rst_out", 32'(o0), 32'h0);
        check("rst_ch",  32'(oc0), 32'h0);
        check("rst_en",  32'(en0), 32'h0);
        check("rst_tick",32'(t0), 32'h0);

        // manual select
        rst_n = 1'b1; freeze = 1'b0; mode = 1'b0; bus = 32'h4433_2211; sel = 2'd2;
        cycle();
        check("man_out", 32'(o0), 32'h33);
        check("man_ch",  32'(oc0), 32'd2);
        check("man_en",  32'(en0), 32'b0100);
        sel = 2'd0;
        cycle();
        check("man_out0", 32'(o0), 32'h11);

        // out-of-range select on the 3-channel instance
        sel = 2'd3;
        cycle();
        check("oor_out", 32'(o1), 32'h0);
        check("oor_en",  32'(en1), 32'h0);
        check("oor_ch",  32'(oc1), 32'd3);

        // scan through a full period plus wrap
        mode = 1'b1;
        for (int i = 0; i < 17; i++) begin
            cycle();
            check("scan_seq",  32'(oc0), 32'(scan_exp[i]));
            check("scan_tick", 32'(t0),  32'((i % 4 == 0) && (i > 0)));
            check("div1_seq",  32'(oc2), 32'(i % 2));
            check("div1_tick", 32'(t2),  32'(i > 0));
            if (i == 6) check("mid_dwell", 32'(o0), 32'h5A);
            if (i == 5) bus = 32'h4433_5A11;
        end

        // mid-dwell switch to manual and back restarts at channel 0
        mode = 1'b0; sel = 2'd3;
        cycle();
        mode = 1'b1;
        for (int i = 0; i < 7; i++) begin
            cycle();
            check("restart_seq", 32'(oc0), 32'(i / 4));
        end

        // freeze at cnt=2 on channel 1
        freeze = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus = $urandom;
            cycle();
            check("frz_ch",   32'(oc0), 32'd1);
            check("frz_tick", 32'(t0),  32'd0);
        end
        freeze = 1'b0;
        cycle();
        check("rel_ch1", 32'(oc0), 32'd1);
        cycle();
        check("rel_ch2", 32'(oc0), 32'd2);
        check("rel_tick",32'(t0),  32'd1);

        // randomized traffic
        for (int n = 0; n < 800; n++) begin
            bus = $urandom;
            sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 39) == 0) mode = ~mode;
            freeze = ($urandom_range(0, 15) == 0);
            rst_n  = ($urandom_range(0, 199) != 0);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/out_sel_scan.md
# out_sel_scan

Parametrised, registered N-channel output selector for the calculator datapath. It replaces the fixed 4:1 8-bit combinational output mux. It adds two modes: a manual mode with a registered select, and an auto-scan mode that rotates through the channels with a programmable dwell. The scan mode drives the multiplexed display digit enables. The block sits between the result/operand registers and the display driver.

## Interface
- WIDTH, 8, bits per channel (≥1)
- NCH, 4, number of channels (≥2); SELW = $clog2(NCH) is a derived localparam
- DIV, 4, clock cycles each channel is held in scan mode (≥1)

- clk  in  1  rising-edge clock; the only clock
- rst_n  in  1  synchronous, active-low reset; sampled on rising clk
- mode  in  1  0 = manual, 1 = scan
- sel  in  SELW  channel index in manual mode; ignored in scan mode
- freeze  in  1  1 = all internal state and outputs hold
- in_bus  in  NCH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
- out  out  WIDTH  selected channel data (registered)
- out_ch  out  SELW  index of the channel on out (registered)
- ch_en  out  NCH  one-hot enable of the channel on out; all-zero when blanked (registered)
- tick  out  1  one-cycle pulse on the cycle out_ch advances in scan mode

## Operation
- Internal state: cnt (dwell counter, 0..DIV-1), ch (scan channel), mode_q (last-cycle mode).
- Every output is a register. out, out_ch and ch_en are always loaded from the same ch_next, so they are mutually consistent in every cycle.
- Reset (rst_n=0): out=0, out_ch=0, ch_en=0, tick=0, cnt=0, ch=0, mode_q=0. Reset overrides freeze and every other input.
- freeze=1 (reset not asserted): every register holds, including cnt, ch, mode_q and tick. A mode change that happens while frozen is acted on in the first unfrozen cycle.

Manual mode (mode=0, freeze=0):
- ch_next = sel.
- If sel < NCH: out ← slice[sel], out_ch ← sel, ch_en ← 1<<sel.
- If sel ≥ NCH (possible only when NCH is not a power of 2): out ← 0, out_ch ← sel, ch_en ← 0. This is the blanked state.
- cnt ← 0, ch ← 0, tick ← 0.

Scan mode (mode=1, freeze=0):
- Entry cycle (mode_q=0): ch_next = 0, ch ← 0, cnt ← 0 if DIV>1, tick ← 0. Channel 0 is then held for DIV cycles, counting the entry cycle. When DIV=1 the entry cycle acts as a normal terminal cycle of channel 0.
- Otherwise, if cnt == DIV-1: cnt ← 0, ch_next = (ch == NCH-1) ? 0 : ch+1, ch ← ch_next, tick ← 1.
- Otherwise: cnt ← cnt+1, ch_next = ch, tick ← 0.
- out ← slice[ch_next], out_ch ← ch_next, ch_en ← 1<<ch_next.
- in_bus is re-sampled every cycle, so data changes during a dwell appear on out one cycle later.
- Leaving scan for manual takes effect on the first manual cycle: the manual rules apply immediately, and cnt and ch clear.
- mode_q ← mode every unfrozen, non-reset cycle.

## Timing
- Latency: 1 cycle from in_bus, sel or mode to out, out_ch and ch_en. No combinational input-to-output path.
- Scan period: NCH*DIV cycles. tick has exactly one high cycle per channel advance. tick rises in the same cycle that the new out_ch first appears.
- With DIV=1, out_ch changes every cycle and tick stays high continuously, except in the entry cycle.
- Wrap-around: NCH-1 → 0 follows the same tick and dwell rules as any other advance.
- Mid-dwell mode switch: the partial dwell is discarded, and a re-entry to scan always restarts at channel 0 with a full dwell.
- Reset asserted mid-scan: outputs are zero on the next edge. The first unfrozen cycle after reset behaves as a mode entry.
- cnt is $clog2(DIV) bits wide, with a minimum of 1.

## Test plan
- Reset: drive rst_n=0 with freeze=1, mode=1 and in_bus non-zero → after 1 edge, out=0, out_ch=0, ch_en=0, tick=0.
- Manual select (WIDTH=8, NCH=4): in_bus = {8'h44,8'h33,8'h22,8'h11}, sel=2 → next cycle out=8'h33, out_ch=2, ch_en=4'b0100. Then sel=0 → out=8'h11 one cycle later.
- Out-of-range select (NCH=3): sel=3 → out=0, ch_en=3'b000, out_ch=3.
- Scan (NCH=4, DIV=4): set mode=1 → out_ch sequence 0,0,0,0,1,1,1,1,2,…,3,3,3,3,0. tick is high on the first cycle of channels 1, 2, 3 and of channel 0 after the wrap, and only there. Changing slice 1 mid-dwell shows up on out 1 cycle later.
- Freeze and mode switch: assert freeze for 5 cycles at cnt=2 on channel 1 → all outputs and tick hold; after release, channel 1 gets 1 more cycle and then advances. Switching to manual mid-dwell and back → scan restarts at channel 0 with a full 4-cycle dwell.
- DIV=1, NCH=2: mode=1 → out_ch sequence 0,1,0,1… with tick=1 from the second scan cycle onward.
